// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the FIFO write-port arbiter.
// The FIFO geometry must match the FIFO instance this arbiter sits in front of.
package fifo_wr_arbiter_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer request lines and FIFO write-side signals seen by the arbiter.
// Handshake: a transfer occurs at posedge clk when req[i] && gnt[i]; a producer holds req/data until granted.
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH
) ();

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_overflow;
    logic                          wr_en;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic [IDX_W-1:0]              owner;
    logic                          ovf_err;

    modport master (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        output gnt, wr_en, data_in, owner, ovf_err
    );

    modport slave (
        output req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        input  gnt, wr_en, data_in, owner, ovf_err
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic priority encoder: first requester at or after start_i, as one-hot grant and index.
module fifo_wr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    int j;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = |req_i;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(start_i) + k) % NUM_REQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded, full-aware arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus,
    output arb_state_e         dbg_state_o,
    output logic [CNT_W-1:0]   dbg_burst_cnt_o,
    output logic [IDX_W-1:0]   dbg_rr_ptr_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
    logic                  ovf_err_q;

    logic [IDX_W-1:0]      owner_inc, pick_start, pick_idx, win_idx;
    logic [NUM_REQ-1:0]    pick_gnt, win_gnt;
    logic                  pick_vld, accept_ok, cont, hs;
    logic [FIFO_WIDTH-1:0] win_data;

    // A write already in flight will land this edge, so almost-full is as good as full.
    assign accept_ok  = !bus.fifo_full && !(wr_en_q && bus.fifo_almostfull);
    assign owner_inc  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign pick_start = (state_q == ST_BURST) ? owner_inc : rr_ptr_q;
    assign cont       = (state_q == ST_BURST) && bus.req[owner_q]
                        && (burst_cnt_q < CNT_W'(MAX_BURST));

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (bus.req),
        .start_i (pick_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .vld_o   (pick_vld)
    );

    assign win_idx  = cont ? owner_q : pick_idx;
    assign win_gnt  = cont ? (NUM_REQ'(1) << owner_q) : pick_gnt;
    assign win_data = bus.req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    assign hs       = rst_n && accept_ok && (cont || pick_vld);
    assign bus.gnt  = hs ? win_gnt : '0;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        data_in_d   = data_in_q;
        if (hs) begin
            state_d   = ST_BURST;
            owner_d   = win_idx;
            data_in_d = win_data;
            if (cont) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = CNT_W'(1);
                if (state_q == ST_BURST) rr_ptr_d = owner_inc;
            end
        end else if (accept_ok && (state_q == ST_BURST) && !(|bus.req)) begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
            rr_ptr_d    = owner_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            wr_en_q     <= 1'b0;
            data_in_q   <= '0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            wr_en_q     <= hs;
            data_in_q   <= data_in_d;
            ovf_err_q   <= ovf_err_q | bus.fifo_overflow;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.data_in     = data_in_q;
    assign bus.owner       = owner_q;
    assign bus.ovf_err     = ovf_err_q;
    assign dbg_state_o     = arb_state_e'(state_q);
    assign dbg_burst_cnt_o = burst_cnt_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a FIFO model
// and a rule-level arbitration reference with a data scoreboard.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int W     = FIFO_WIDTH;
  localparam int MAXB  = 4;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int IDX_W = 2;
  localparam int CNT_W = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

  arb_state_e       dbg_state;
  logic [CNT_W-1:0] dbg_cnt;
  logic [IDX_W-1:0] dbg_ptr;

  fifo_wr_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .dbg_state_o     (dbg_state),
    .dbg_burst_cnt_o (dbg_cnt),
    .dbg_rr_ptr_o    (dbg_ptr)
  );

  // producers and FIFO environment
  logic [N-1:0] req_v = '0;
  logic [W-1:0] pdata [N];
  int           fifo_cnt = 0;
  logic         rd_en = 1'b1;
  logic         ovf_force = 1'b0;
  logic         ovf_pulse = 1'b0;

  assign bus.req             = req_v;
  assign bus.fifo_full       = (fifo_cnt == DEPTH);
  assign bus.fifo_almostfull = (fifo_cnt == DEPTH - 1);
  assign bus.fifo_overflow   = ovf_force | ovf_pulse;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_data[g*W +: W] = pdata[g];
  end

  // reference model and scoreboard
  bit           m_busy = 0;
  int           m_owner = 0;
  int           m_cnt = 0;
  int           m_ptr = 0;
  bit           m_wr = 0;
  bit           m_ovf = 0;
  logic [W-1:0] exp_q [$];
  int           compared = 0;
  int           failed = 0;
  int           writes_seen = 0;
  int           accepts = 0;
  int           last_win = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_accept();
    return !(fifo_cnt == DEPTH || (m_wr && fifo_cnt == DEPTH - 1));
  endfunction

  function automatic int model_winner();
    int start;
    if (!model_accept() || req_v == '0) return -1;
    if (m_busy && req_v[m_owner] && m_cnt < MAXB) return m_owner;
    start = m_busy ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++)
      if (req_v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_wr = 0; m_ovf = 0;
    exp_q.delete();
    fifo_cnt = 0; ovf_pulse = 1'b0; ovf_force = 1'b0;
  endtask

  // Driver: one clock cycle, entered and left at a negedge.
  task automatic step();
    int win, c;
    logic dut_wr, ovf_s;
    logic [N-1:0] exp_gnt;
    bit acc_s, cont_s;
    #1;
    win     = model_winner();
    exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
    check("gnt", bus.gnt, exp_gnt);
    dut_wr = bus.wr_en;
    ovf_s  = bus.fifo_overflow;
    acc_s  = model_accept();
    cont_s = m_busy && req_v[m_owner] && m_cnt < MAXB;
    last_win = win;
    @(posedge clk);
    #1;
    if (ovf_s) m_ovf = 1;
    if (win >= 0) begin
      if (cont_s) m_cnt++;
      else begin
        if (m_busy) m_ptr = (m_owner + 1) % N;
        m_cnt = 1;
      end
      m_busy = 1; m_owner = win; m_wr = 1;
      exp_q.push_back(pdata[win]);
      accepts++;
    end else begin
      m_wr = 0;
      if (acc_s && m_busy && req_v == '0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    c = fifo_cnt;
    ovf_pulse = dut_wr && c == DEPTH && !rd_en;
    if (rd_en && c > 0) fifo_cnt--;
    if (dut_wr === 1'b1 && !(c == DEPTH && !rd_en)) fifo_cnt++;
    @(negedge clk);
    check("wr_en", bus.wr_en, m_wr);
    if (bus.wr_en === 1'b1) writes_seen++;
    if (m_wr) check("data_in", bus.data_in, exp_q.pop_front());
    check("owner", bus.owner, m_owner);
    check("ovf_err", bus.ovf_err, m_ovf);
    check("state", dbg_state, m_busy);
    if (m_busy) check("burst_cnt", dbg_cnt, m_cnt);
    check("rr_ptr", dbg_ptr, m_ptr);
  endtask

  task automatic refresh_winner();
    if (last_win >= 0) pdata[last_win] = W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_v = '0;
    rd_en = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) pdata[i] = W'($urandom);
    req_v = 4'hf;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_ovf_err", bus.ovf_err, 0);
    check("rst_state", dbg_state, 0);
    check("rst_burst_cnt", dbg_cnt, 0);
    check("rst_rr_ptr", dbg_ptr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all producers requesting, FIFO drained every cycle
    req_v = 4'hf;
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      check("t1_owner_seq", bus.owner, (k / 4) % 4);
      check("t1_wr_en_high", bus.wr_en, 1);
      refresh_winner();
    end

    // 2: producer 0 leaves after two accepts, producer 2 takes over with no gap
    do_reset();
    req_v = 4'b0101;
    step(); refresh_winner();
    step(); refresh_winner();
    check("t2_owner_before", bus.owner, 0);
    req_v = 4'b0100;
    step();
    check("t2_owner_switch", bus.owner, 2);
    check("t2_no_gap", bus.wr_en, 1);

    // 3: fill with no reads
    do_reset();
    rd_en = 1'b0;
    req_v = 4'hf;
    writes_seen = 0;
    accepts = 0;
    repeat (12) begin
      step();
      refresh_winner();
    end
    check("t3_writes", writes_seen, 8);
    check("t3_accepts", accepts, 8);
    check("t3_ovf_err", bus.ovf_err, 0);
    #1;
    check("t3_gnt_full", bus.gnt, 0);

    // 4: stall keeps burst state, one read frees exactly one slot
    step();
    step();
    check("t4_cnt_hold", dbg_cnt, 4);
    check("t4_owner_hold", bus.owner, 1);
    accepts = 0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    repeat (4) begin
      step();
      refresh_winner();
    end
    check("t4_one_accept", accepts, 1);
    check("t4_owner_rot", bus.owner, 2);

    // 6: one-cycle overflow pulse sets a sticky error
    rd_en = 1'b1;
    ovf_force = 1'b1;
    step();
    ovf_force = 1'b0;
    check("t6_ovf_set", bus.ovf_err, 1);
    repeat (5) begin
      step();
      refresh_winner();
    end
    check("t6_ovf_hold", bus.ovf_err, 1);

    // 5: asynchronous reset between edges in the middle of a burst
    req_v = 4'hf;
    repeat (3) begin
      step();
      refresh_winner();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_gnt", bus.gnt, 0);
    check("t5_wr_en", bus.wr_en, 0);
    check("t5_owner", bus.owner, 0);
    check("t5_ovf_err", bus.ovf_err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5_restart_owner", bus.owner, 0);
    refresh_winner();

    // random traffic with varying drain rate
    for (int s = 0; s < 400; s++) begin
      if (last_win >= 0) begin
        if ($urandom_range(0, 1) == 0) req_v[last_win] = 1'b0;
        else pdata[last_win] = W'($urandom);
      end
      for (int i = 0; i < N; i++)
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i] = 1'b1;
          pdata[i] = W'($urandom);
        end
      rd_en = (s < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      step();
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
